// File: rtl/axi_lite_pmem_bridge.sv
// AXI4-Lite slave that turns read/write transactions into the single-cycle
// strobes of the physical-memory model. The bridge adds a fixed latency,
// holds responses until handshake, and gives a write commit priority over a
// read issuing in the same cycle.
module axi_lite_pmem_bridge #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WR_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  // AXI read address / data
  input  logic        arvalid,
  output logic        arready,
  input  logic [63:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  // AXI write address / data / response
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  // Pmem ports
  output logic [63:0] pmem_raddr,
  output logic        pmem_rvalid,
  input  logic [63:0] pmem_rdata,
  output logic [63:0] pmem_waddr,
  output logic [63:0] pmem_wdata,
  output logic [7:0]  pmem_mask
);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_e;

  localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LATENCY - 1);

  rstate_e     r_state_q, r_state_d;
  logic [3:0]  r_cnt_q, r_cnt_d;
  logic [63:0] raddr_q, raddr_d;
  logic [63:0] rdata_q, rdata_d;

  wstate_e     w_state_q, w_state_d;
  logic [3:0]  w_cnt_q, w_cnt_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [63:0] waddr_q, waddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;

  logic        commit;
  logic        aw_fire;
  logic        w_fire;

  // Commit cycle: write counter expired while waiting; also blocks a read issue.
  assign commit = (w_state_q == W_WAIT) && (w_cnt_q == '0);

  assign arready    = (r_state_q == R_IDLE);
  assign rvalid     = (r_state_q == R_RESP);
  assign rdata      = rdata_q;
  assign rresp      = 2'b00;
  assign pmem_raddr = raddr_q;

  assign awready    = (w_state_q == W_IDLE) && !aw_held_q;
  assign wready     = (w_state_q == W_IDLE) && !w_held_q;
  assign bvalid     = (w_state_q == W_RESP);
  assign bresp      = 2'b00;
  assign pmem_waddr = waddr_q;
  assign pmem_wdata = wdata_q;

  // State and datapath registers for both channels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Read FSM: accept AR, count down latency, issue strobe, hold R until taken.
  always_comb begin
    r_state_d   = r_state_q;
    r_cnt_d     = r_cnt_q;
    raddr_d     = raddr_q;
    rdata_d     = rdata_q;
    pmem_rvalid = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          raddr_d   = araddr;
          r_cnt_d   = RD_LOAD;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q != '0) begin
          r_cnt_d = r_cnt_q - 4'd1;
        end else if (!commit) begin
          pmem_rvalid = 1'b1;
          rdata_d     = pmem_rdata;
          r_state_d   = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM: gather AW and W in any order, count down, pulse mask once, hold B.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    pmem_mask = '0;
    case (w_state_q)
      W_IDLE: begin
        aw_fire = awvalid && !aw_held_q;
        w_fire  = wvalid && !w_held_q;
        if (aw_fire) begin
          waddr_d   = awaddr;
          aw_held_d = 1'b1;
        end
        if (w_fire) begin
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          w_held_d = 1'b1;
        end
        // A beat arriving this cycle counts as held so the pair can launch now.
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_cnt_d   = WR_LOAD;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_q != '0) begin
          w_cnt_d = w_cnt_q - 4'd1;
        end else begin
          pmem_mask = wstrb_q;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

endmodule

// File: doc/axi_lite_pmem_bridge.md
# axi_lite_pmem_bridge

AXI4-Lite slave that converts core memory transactions into the single-cycle DPI strobes of the physical-memory model. It sits directly upstream of the Pmem block, between the core's memory arbiter and Pmem. It adds configurable read and write latency, holds AXI responses stable until handshake, and guarantees exactly one `pmem_mask` pulse per write. A write committing in the same cycle as a read is ordered before that read.

## Interface
- `RD_LATENCY`, 1: cycles from AR handshake to the Pmem read strobe, legal range 1..15.
- `WR_LATENCY`, 1: cycles from AW+W both captured to the Pmem write strobe, legal range 1..15.

- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `arvalid` in 1, `arready` out 1, `araddr` in 64: AXI read address channel.
- `rvalid` out 1, `rready` in 1, `rdata` out 64, `rresp` out 2: AXI read data channel.
- `awvalid` in 1, `awready` out 1, `awaddr` in 64: AXI write address channel.
- `wvalid` in 1, `wready` out 1, `wdata` in 64, `wstrb` in 8: AXI write data channel.
- `bvalid` out 1, `bready` in 1, `bresp` out 2: AXI write response channel.
- `pmem_raddr` out 64, `pmem_rvalid` out 1, `pmem_rdata` in 64: Pmem read port. `pmem_rdata` is combinational from `pmem_raddr` while `pmem_rvalid=1`, and garbage otherwise.
- `pmem_waddr` out 64, `pmem_wdata` out 64, `pmem_mask` out 8: Pmem write port. Any cycle with nonzero mask performs a write.

## Operation
- Read FSM states are R_IDLE, R_WAIT and R_RESP.
  - R_IDLE: `arready=1`. On `arvalid&&arready`, latch `araddr` into `pmem_raddr`, load the counter with `RD_LATENCY-1`, and go to R_WAIT.
  - R_WAIT: `arready=0`. When the counter is nonzero, decrement it.
  - When the counter is 0 and no write commits this cycle: drive `pmem_rvalid=1`, register `pmem_rdata` into `rdata`, and go to R_RESP.
  - When the counter is 0 and a write commits this cycle: `pmem_rvalid` stays 0 and the FSM stays in R_WAIT one more cycle.
  - R_RESP: `rvalid=1`, `rresp=2'b00`, `rdata` is held stable. On `rready`, go to R_IDLE.
- Write FSM states are W_IDLE, W_WAIT and W_RESP.
  - W_IDLE: `awready=!aw_held` and `wready=!w_held`. AW and W are accepted independently, in any order or in the same cycle, and latched into `pmem_waddr`/`pmem_wdata` and a strobe register.
  - Once both are held, clear the held flags, load the counter with `WR_LATENCY-1`, and go to W_WAIT. `awready` and `wready` are 0 outside W_IDLE.
  - W_WAIT: decrement the counter. The cycle the counter is 0 is the commit cycle: `pmem_mask` = latched `wstrb` for exactly that cycle, then go to W_RESP.
  - W_RESP: `bvalid=1`, `bresp=2'b00`. On `bready`, go to W_IDLE.
- `pmem_mask` is 8'h00 in every cycle except a commit cycle.
- `pmem_rvalid` is 0 in every cycle except a read-issue cycle.
- Addresses pass through unmodified. Byte-lane selection and alignment belong to the Pmem model and the master.
- A `wstrb=0` write still runs the full sequence and returns B. The commit cycle drives 8'h00, which causes no memory write.
- Read and write channels are fully independent, except for the commit-over-read ordering rule above.

## Timing
- While `reset` is asserted, and immediately on assertion:
  - FSMs in IDLE, held flags cleared.
  - `arready=1`, `awready=1`, `wready=1`.
  - `rvalid=0`, `bvalid=0`, `pmem_rvalid=0`, `pmem_mask=0`.
  - `rdata`, `pmem_raddr`, `pmem_waddr`, `pmem_wdata` = 0.
  - `rresp=bresp=0`.
- Reset mid-transaction discards it: no later `pmem_mask` pulse, no `rvalid`, no `bvalid`.
- Read latency: AR handshake at edge N; `pmem_rvalid` high in cycle N+RD_LATENCY; `rvalid` high from cycle N+RD_LATENCY+1. Add one cycle per collision with a write commit.
- Write latency: last of AW/W captured at edge N; commit in cycle N+WR_LATENCY; `bvalid` high from cycle N+WR_LATENCY+1.
- Back-to-back: after an R handshake at edge M, `arready=1` in cycle M+1. There is no outstanding-transaction depth beyond 1 per channel.
- Response stability: once `rvalid` or `bvalid` rises, it and its payload are unchanged until the handshake, regardless of new `arvalid`/`awvalid`.
- Counters are 4 bits. The counter at 0 is the terminal state, with no wrap.

## Test plan
- Reset release, then AR `araddr=0x80000008`, `pmem_rdata` model returns 0x1122334455667788, `rready=1`, RD_LATENCY=1:
  - `pmem_rvalid` pulses in cycle 1 after the handshake.
  - `rvalid` is high in cycle 2 with `rdata=0x1122334455667788` and `rresp=0`.
- W presented 3 cycles before AW (`awaddr=0x80000010`, `wdata=0xDEADBEEF`, `wstrb=0x0F`), WR_LATENCY=2:
  - `wready` drops after the W capture.
  - A single `pmem_mask=0x0F` pulse occurs 2 cycles after AW capture.
  - `bvalid` is high the next cycle and held until `bready` goes high 4 cycles later.
- Write commit to 0x80000020 in the same cycle a read of 0x80000020 reaches its issue point:
  - `pmem_mask` pulses first.
  - `pmem_rvalid` pulses one cycle later.
  - `rdata` equals the newly written data.
- `rready=0` for 5 cycles while `arvalid` stays asserted with a new address:
  - `rdata` and `rvalid` stay stable.
  - `arready` stays 0.
  - The second read issues only after the R handshake.
- Assert `reset` during W_WAIT (WR_LATENCY=3, after 1 wait cycle):
  - No `pmem_mask` pulse ever appears.
  - `bvalid` stays 0.
  - All ready signals are 1 immediately.
- `wstrb=0x00` write:
  - Full handshake completes.
  - `pmem_mask` stays 0 throughout.
  - `bvalid` asserts with `bresp=0`.
